// File: rtl/ltc235x_cfg_pkg.sv
// Shared definitions for the LTC235x SoftSpan configuration loader.
// Holds the FSM state encoding, the SoftSpan word width, the field
// positions inside the GPIO output word and the bit positions inside the
// status word returned to the GPIO input register.
package ltc235x_cfg_pkg;

  localparam int SPAN_W = 24;

  // gpio_word field positions
  localparam int START_BIT = 31;
  localparam int SPAN_LSB  = 0;
  localparam int SPAN_MSB  = 23;

  // status_word bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/ltc235x_softspan_loader.sv
// Serial configuration engine for the LTC235x SoftSpan port.
// A rising edge on gpio_word[31] latches gpio_word[23:0] and shifts it
// MSB-first into the ADC over a cs_n/sck/sdi frame; sck half-period is
// CLK_DIV clk cycles. Software polls status_word for completion.
//
// Ports:
//   clk, reset_n     system clock, asynchronous active-low reset
//   gpio_word[31:0]  GPIO output word: [31] start, [30:24] reserved, [23:0] span
//   adc_cs_n         frame select, active-low
//   adc_sck          serial clock, ADC samples on rising edge
//   adc_sdi          serial data, changes only while adc_sck is low
//   status_word      {29'b0, overrun, done, busy}
//   dbg_state        current FSM state, for observation only
//
// Handshake: there is no valid/ready pair; a start is the 0->1 transition of
// gpio_word[31] seen against its registered copy. A start seen while a frame
// is in flight is dropped and recorded in the sticky overrun flag.
module ltc235x_softspan_loader #(
  parameter int CLK_DIV = 4,
  parameter int SPAN_W  = ltc235x_cfg_pkg::SPAN_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] gpio_word,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_sdi,
  output logic [31:0] status_word,
  output logic [2:0]  dbg_state
);
  import ltc235x_cfg_pkg::*;

  localparam logic [7:0] PHASE_INIT = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_INIT   = 5'(SPAN_W - 1);

  state_e              state_q, state_d;
  logic [7:0]          phase_q, phase_d;
  logic [4:0]          bit_q, bit_d;
  logic [SPAN_W-1:0]   shreg_q, shreg_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                start_q;
  logic                start_pulse;
  logic                phase_zero;

  // Reserved GPIO bits are intentionally not decoded.
  logic                unused_reserved;
  assign unused_reserved = ^gpio_word[30:24];

  assign start_pulse = gpio_word[START_BIT] & ~start_q;
  assign phase_zero  = (phase_q == 8'd0);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    cs_n_d    = cs_n_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    done_d    = done_q;
    overrun_d = overrun_q;

    // Every state dwells CLK_DIV cycles: the phase counter is reloaded on
    // each state entry and the state exits on the cycle it reads zero.
    if (state_q != ST_IDLE && !phase_zero) begin
      phase_d = phase_q - 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          state_d   = ST_SETUP;
          phase_d   = PHASE_INIT;
          bit_d     = BIT_INIT;
          shreg_d   = gpio_word[SPAN_MSB:SPAN_LSB];
          cs_n_d    = 1'b0;
          sdi_d     = gpio_word[SPAN_MSB];
          done_d    = 1'b0;
          overrun_d = 1'b0;
        end
      end
      ST_SETUP, ST_SCK_LO: begin
        if (phase_zero) begin
          state_d = ST_SCK_HI;
          phase_d = PHASE_INIT;
          sck_d   = 1'b1;
        end
      end
      ST_SCK_HI: begin
        if (phase_zero) begin
          phase_d = PHASE_INIT;
          sck_d   = 1'b0;
          if (bit_q == 5'd0) begin
            state_d = ST_HOLD;
            sdi_d   = 1'b0;
          end else begin
            // sdi moves on the falling sck edge so it is stable for a full
            // half-period before the next rising edge.
            state_d = ST_SCK_LO;
            sdi_d   = shreg_q[SPAN_W-2];
            shreg_d = shreg_q << 1;
            bit_d   = bit_q - 5'd1;
          end
        end
      end
      ST_HOLD: begin
        if (phase_zero) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        sdi_d   = 1'b0;
      end
    endcase

    if (start_pulse && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= 8'd0;
      bit_q     <= 5'd0;
      shreg_q   <= '0;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      // Reset high so a start bit already held at reset release is not a start.
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      start_q   <= gpio_word[START_BIT];
    end
  end

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = busy_q;
    status_word[STAT_DONE]    = done_q;
    status_word[STAT_OVERRUN] = overrun_q;
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sck   = sck_q;
  assign adc_sdi   = sdi_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ltc235x_softspan_loader.sv
// Bench for ltc235x_softspan_loader: one instance with CLK_DIV=4 and one with
// CLK_DIV=1. A passive monitor per instance reconstructs each frame (cs_n low
// cycles, sck rises, sdi bits at each rise) and a word scoreboard holds the
// span words the reference model expects to see on the wire.
module tb_ltc235x_softspan_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [31:0] gpio4, gpio1;
  logic        cs4, sck4, sdi4, cs1, sck1, sdi1;
  logic [31:0] st4, st1;
  logic [2:0]  dbg4, dbg1;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];

  ltc235x_softspan_loader #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .gpio_word(gpio4),
    .adc_cs_n(cs4), .adc_sck(sck4), .adc_sdi(sdi4),
    .status_word(st4), .dbg_state(dbg4)
  );

  ltc235x_softspan_loader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .gpio_word(gpio1),
    .adc_cs_n(cs1), .adc_sck(sck1), .adc_sdi(sdi1),
    .status_word(st1), .dbg_state(dbg1)
  );

  // ---------------- monitors ----------------
  logic        cs4_p = 1'b1, sck4_p = 1'b0, sdi4_p = 1'b0;
  logic        cs1_p = 1'b1, sck1_p = 1'b0, sdi1_p = 1'b0;
  int          low4 = 0, rises4 = 0, viol4 = 0, low1 = 0, rises1 = 0, viol1 = 0;
  logic [23:0] rx4 = '0, rx1 = '0;

  always @(negedge clk) begin
    cs4_p <= cs4; sck4_p <= sck4; sdi4_p <= sdi4;
    if (!cs4) begin
      if (cs4_p) begin low4 <= 1; rises4 <= 0; rx4 <= '0; end
      else low4 <= low4 + 1;
    end
    if (!cs4 && sck4 && !sck4_p) begin
      rises4 <= rises4 + 1;
      rx4    <= {rx4[22:0], sdi4};
    end
    if (sdi4 != sdi4_p && sck4) viol4 <= viol4 + 1;
  end

  always @(negedge clk) begin
    cs1_p <= cs1; sck1_p <= sck1; sdi1_p <= sdi1;
    if (!cs1) begin
      if (cs1_p) begin low1 <= 1; rises1 <= 0; rx1 <= '0; end
      else low1 <= low1 + 1;
    end
    if (!cs1 && sck1 && !sck1_p) begin
      rises1 <= rises1 + 1;
      rx1    <= {rx1[22:0], sdi1};
    end
    if (sdi1 != sdi1_p && sck1) viol1 <= viol1 + 1;
  end

  // ---------------- driver tasks ----------------
  // Lower bit 31 for one cycle with the new span word, then raise it; the
  // frame must launch on the very next clk edge.
  task automatic start_frame(input bit sel, input logic [23:0] w);
    logic c;
    @(posedge clk); #1;
    if (sel) gpio1 = {1'b0, 7'($urandom), w};
    else     gpio4 = {1'b0, 7'($urandom), w};
    @(posedge clk); #1;
    if (sel) gpio1[31] = 1'b1;
    else     gpio4[31] = 1'b1;
    exp_q.push_back(w);
    @(posedge clk); #1;
    c = sel ? cs1 : cs4;
    checks++;
    if (c !== 1'b0) begin
      errors++;
      $display("FAIL start_latency sel=%0d cs_n=%b expected 0", sel, c);
    end
  endtask

  task automatic wait_frame_end(input bit sel, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel ? cs1 : cs4) === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout sel=%0d cs_n still low after %0d cycles", sel, budget);
    end
  endtask

  // Compare a completed frame against the reference: length 49*CLK_DIV,
  // 24 sck rises, and the oldest expected word on the wire.
  task automatic check_frame(input bit sel, input int clk_div, input logic [31:0] exp_st);
    logic [23:0] w;
    int lo, ri;
    logic [23:0] rx;
    logic [31:0] st;
    w  = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
    lo = sel ? low1 : low4;
    ri = sel ? rises1 : rises4;
    rx = sel ? rx1 : rx4;
    st = sel ? st1 : st4;
    checks++;
    if (lo != 49 * clk_div) begin
      errors++; $display("FAIL frame_len sel=%0d got %0d expected %0d", sel, lo, 49 * clk_div);
    end
    checks++;
    if (ri != 24) begin
      errors++; $display("FAIL sck_rises sel=%0d got %0d expected 24", sel, ri);
    end
    checks++;
    if (rx !== w) begin
      errors++; $display("FAIL sdi_data sel=%0d got %h expected %h", sel, rx, w);
    end
    checks++;
    if (st !== exp_st) begin
      errors++; $display("FAIL status_after sel=%0d got %h expected %h", sel, st, exp_st);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset_n = 1'b0;
    gpio4 = 32'h8000_0000;
    gpio1 = 32'h8000_0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (cs4 !== 1'b1 || sck4 !== 1'b0 || sdi4 !== 1'b0) begin
      errors++; $display("FAIL reset_pins4 got cs=%b sck=%b sdi=%b expected 1 0 0", cs4, sck4, sdi4);
    end
    checks++;
    if (st4 !== 32'h0) begin
      errors++; $display("FAIL reset_status4 got %h expected 0", st4);
    end
    checks++;
    if (cs1 !== 1'b1 || st1 !== 32'h0) begin
      errors++; $display("FAIL reset_dut1 got cs=%b st=%h expected 1 0", cs1, st1);
    end
  endtask

  task automatic test_frame;
    logic [23:0] words[3];
    words[0] = 24'hA5C396;
    words[1] = 24'($urandom);
    words[2] = 24'($urandom);
    foreach (words[k]) begin
      start_frame(1'b0, words[k]);
      @(negedge clk); #1;
      checks++;
      if (st4 !== 32'h1) begin
        errors++; $display("FAIL status_busy got %h expected 1", st4);
      end
      wait_frame_end(1'b0, 400);
      check_frame(1'b0, 4, 32'h2);
      repeat ($urandom_range(1, 5)) @(posedge clk);
    end
  endtask

  task automatic test_overrun;
    logic [23:0] w1, w2, w3;
    w1 = 24'($urandom);
    w2 = ~w1;
    w3 = 24'($urandom);
    start_frame(1'b0, w1);
    repeat (60) @(posedge clk);
    #1 gpio4 = {1'b0, 7'h0, w2};
    @(posedge clk); #1 gpio4[31] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (st4 !== 32'h5) begin
      errors++; $display("FAIL status_overrun got %h expected 5", st4);
    end
    wait_frame_end(1'b0, 400);
    check_frame(1'b0, 4, 32'h6);
    start_frame(1'b0, w3);
    @(negedge clk);
    checks++;
    if (st4 !== 32'h1) begin
      errors++; $display("FAIL overrun_clear got %h expected 1", st4);
    end
    wait_frame_end(1'b0, 400);
    check_frame(1'b0, 4, 32'h2);
  endtask

  task automatic test_back_to_back;
    start_frame(1'b1, 24'hFFFFFF);
    wait_frame_end(1'b1, 200);
    check_frame(1'b1, 1, 32'h2);
    start_frame(1'b1, 24'h000000);
    wait_frame_end(1'b1, 200);
    check_frame(1'b1, 1, 32'h2);
    checks++;
    if (viol1 != 0 || viol4 != 0) begin
      errors++; $display("FAIL sdi_while_sck_high got %0d/%0d expected 0/0", viol1, viol4);
    end
  endtask

  task automatic test_reserved;
    int bad = 0;
    @(posedge clk); #1 gpio4[31] = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      #1 gpio4 = {1'b1, 7'($urandom), 24'($urandom)};
      @(negedge clk);
      if (cs4 !== 1'b1) bad++;
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reserved_no_start got %0d low cycles expected 0", bad);
    end
    checks++;
    if (st4 !== 32'h2) begin
      errors++; $display("FAIL reserved_status got %h expected 2", st4);
    end
  endtask

  task automatic test_reset_mid;
    bit hit = 1'b0;
    start_frame(1'b0, 24'($urandom));
    void'(exp_q.pop_back());
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (rises4 >= 10) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL reset_mid_timeout rises=%0d expected 10", rises4);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (cs4 !== 1'b1 || sck4 !== 1'b0 || sdi4 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pins got cs=%b sck=%b sdi=%b expected 1 0 0", cs4, sck4, sdi4);
    end
    checks++;
    if (st4 !== 32'h0) begin
      errors++; $display("FAIL reset_mid_status got %h expected 0", st4);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (cs4 !== 1'b1 || st4 !== 32'h0) begin
      errors++; $display("FAIL no_resume got cs=%b st=%h expected 1 0", cs4, st4);
    end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_overrun;
    test_back_to_back;
    test_reserved;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ltc235x_softspan_loader.md
# ltc235x_softspan_loader

Serial configuration engine downstream of the 32-bit system GPIO output register. It consumes that register's `out_port` word. On a software start bit it latches a 24-bit LTC235x SoftSpan word and shifts it MSB-first into the ADC's configuration port over an SPI-style frame. It returns a status word for a GPIO input register, so software can poll for completion.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per SCK half-period; legal range 1..255.
- `SPAN_W`, default 24: SoftSpan word width (3 bits × 8 channels); fixed for LTC235x.

Ports:
- `clk`, in, 1: system clock, same domain as the GPIO register.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `gpio_word`, in, 32: GPIO output word.
  - [23:0] SoftSpan word, channel 7 in [23:21] down to channel 0 in [2:0].
  - [31] start, acting on its rising edge.
  - [30:24] reserved and ignored.
- `adc_cs_n`, out, 1: configuration frame select, active-low.
- `adc_sck`, out, 1: serial clock; the ADC samples on the rising edge.
- `adc_sdi`, out, 1: serial data; changes only while `adc_sck` is low.
- `status_word`, out, 32: {29'b0, overrun, done, busy}.

Clock and reset: reset reset_n, asynchronous, active-low; clock clk.

## Operation
- Start detect:
  - `start_q` is a registered copy of `gpio_word[31]`; its reset value is 1, so a bit already held high at reset release does not launch a frame.
  - A start is `gpio_word[31] & ~start_q`.
- Accepted start (FSM in IDLE):
  - latch `gpio_word[23:0]` into the shift register;
  - clear `done` and `overrun`;
  - enter SETUP.
- Start while not IDLE:
  - ignored, and the in-flight frame continues unchanged;
  - `overrun` is set and stays set until the next accepted start.
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD.
  - IDLE: `cs_n`=1, `sck`=0, `sdi`=0. Accepted start → SETUP, with `cs_n`=0 and `sdi`=bit 23.
  - SETUP: lasts `CLK_DIV` cycles → SCK_HI, with `sck`=1.
  - SCK_HI: lasts `CLK_DIV` cycles. If the bit counter is 0 → HOLD, with `sck`=0 and `sdi`=0. Otherwise → SCK_LO, with `sck`=0, shift left, `sdi`=next bit, counter−1.
  - SCK_LO: lasts `CLK_DIV` cycles → SCK_HI, with `sck`=1.
  - HOLD: lasts `CLK_DIV` cycles → IDLE, with `cs_n`=1, `done`=1.
- Counters:
  - bit counter: 5 bits, loaded with `SPAN_W`−1 = 23 at start.
  - phase counter: 8 bits, loaded with `CLK_DIV`−1 on each state entry; it counts down, and the state exits when it reads 0.
- `busy`=1 in every state other than IDLE.
- `done` is sticky and clears only on an accepted start or on reset.
- Reset mid-frame: all outputs return to IDLE values immediately (asynchronous); the ADC sees `cs_n` rise, which aborts the partial word. No frame resumes after reset.

## Timing
- All outputs are registered, with no combinational path from `gpio_word` to any output.
- Reset values:
  - `adc_cs_n`=1, `adc_sck`=0, `adc_sdi`=0;
  - `status_word`=0;
  - FSM in IDLE, `start_q`=1.
- Start latency: `cs_n` falls at the first clk edge at which `gpio_word[31]`=1 and `start_q`=0, which is one edge after the GPIO register write lands.
- Frame length, counting `cs_n` low cycles: `CLK_DIV`×(1 + 24 + 23 + 1) = 49×`CLK_DIV`. With `CLK_DIV`=4 this is 196 cycles.
- Data setup: `sdi` is stable `CLK_DIV` cycles before each `sck` rise and is held `CLK_DIV` cycles after it.
- `done` rises on the same edge as `cs_n` rises; `busy` falls on that edge.
- Back-to-back frames: software needs a 0→1 transition on bit 31, so the minimum `cs_n`-high gap is 1 cycle, plus the GPIO write time.
- `CLK_DIV`=1: SCK is clk/2. All state dwell times are one cycle; no state is skipped.

## Structure
- The shared include/package `ltc235x_cfg_pkg` holds:
  - FSM state encodings;
  - `SPAN_W`;
  - `gpio_word` field positions: START_BIT=31, SPAN_LSB=0, SPAN_MSB=23;
  - `status_word` bit positions: BUSY=0, DONE=1, OVERRUN=2.
- Single module; no sub-module is warranted. The phase counter and bit counter stay inline with the FSM.

## Test plan
- Reset with `gpio_word`=32'h8000_0000 held, then release → no frame; `cs_n` stays 1 and `status_word`=0.
- Load 24'hA5C3_96 and toggle bit 31 0→1 with `CLK_DIV`=4 → `cs_n` low for 196 cycles, 24 `sck` rises, SDI bits sampled at the rises equal 0xA5C396 MSB-first, then `status_word`=32'h2.
- Issue a second 0→1 on bit 31 mid-frame with a different span word → the first frame's serial data is unchanged, `status_word`=32'h5 during the frame and 32'h6 after it; the next accepted start clears the overrun flag.
- Assert `reset_n` after the 10th `sck` rise → `cs_n`=1, `sck`=0, `sdi`=0 with no clk edge needed; the status word reads 0.
- `CLK_DIV`=1 with span word 24'hFFFFFF then 24'h000000 in back-to-back frames → `cs_n` low 49 cycles each, `sck` at clk/2, correct all-ones then all-zeros data.
- Toggle reserved bits [30:24] and hold bit 31 high → no new frame starts.
